// File: rtl/axi_stream_extract_header_if.sv
// AXI-Stream style beat handshake bundle.
// Carries valid/ready plus data, byte keep and last.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WD-1:0]      data;
  logic [DATA_BYTE_WD-1:0] keep;
  logic                    last;

  modport master (
    output valid, data, keep, last,
    input  ready
  );

  modport slave (
    input  valid, data, keep, last,
    output ready
  );
endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips an N-byte header off the first beat of a packet and
// re-emits the remaining payload realigned MSB-first.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_extract_i,
  input  logic [DATA_BYTE_WD-1:0] keep_extract_i,
  output logic                    ready_extract_o,
  axi_stream_extract_header_if.slave  in_if,
  axi_stream_extract_header_if.master hdr_if,
  axi_stream_extract_header_if.master out_if,
  output logic                    err_short_o
);

  localparam int B  = DATA_BYTE_WD;
  localparam int CW = $clog2(B + 1);

  typedef logic [CW-1:0]      cnt_t;
  typedef logic [B-1:0]       keep_t;
  typedef logic [DATA_WD-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE, HDR, BODY, FLUSH
  } state_t;

  function automatic cnt_t popcnt(keep_t k);
    cnt_t c;
    c = '0;
    for (int i = 0; i < B; i++)
      c = c + cnt_t'(k[i]);
    return c;
  endfunction

  function automatic keep_t top_ones(cnt_t m);
    keep_t r;
    r = '0;
    for (int i = 0; i < B; i++)
      if (i < int'(m)) r[B-1-i] = 1'b1;
    return r;
  endfunction

  function automatic keep_t low_ones(cnt_t m);
    keep_t r;
    r = '0;
    for (int i = 0; i < B; i++)
      if (i < int'(m)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic data_t bmask(keep_t k);
    data_t m;
    m = '0;
    for (int i = 0; i < B; i++)
      m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t state_q, state_d;
  cnt_t   n_q, n_d;
  keep_t  kc_q, kc_d;
  data_t  res_q, res_d;
  keep_t  fk_q, fk_d;
  logic   hv_q, hv_d;
  data_t  hd_q, hd_d;
  keep_t  hk_q, hk_d;
  logic   ov_q, ov_d;
  data_t  od_q, od_d;
  keep_t  ok_q, ok_d;
  logic   ol_q, ol_d;
  logic   err_q, err_d;

  cnt_t  k;
  cnt_t  r;
  logic  out_free;
  logic  rdy_in;
  logic  fire;
  data_t beat;
  data_t nres;
  data_t hdr_full;

  assign k        = popcnt(in_if.keep);
  assign r        = cnt_t'(B) - n_q;
  assign out_free = !ov_q || out_if.ready;

  // HDR also waits on the payload register: a short last beat emits
  // payload here and must not overwrite a beat still being held.
  assign rdy_in = (state_q == HDR)  ? (!hv_q && out_free) :
                  (state_q == BODY) ? out_free : 1'b0;
  assign fire   = in_if.valid && rdy_in;

  assign ready_extract_o = (state_q == IDLE);
  assign in_if.ready     = rdy_in;
  assign err_short_o     = err_q;

  assign hdr_if.valid = hv_q;
  assign hdr_if.data  = hd_q;
  assign hdr_if.keep  = hk_q;
  assign hdr_if.last  = 1'b0;

  assign out_if.valid = ov_q;
  assign out_if.data  = od_q;
  assign out_if.keep  = ok_q;
  assign out_if.last  = ol_q;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    kc_d     = kc_q;
    res_d    = res_q;
    fk_d     = fk_q;
    hv_d     = hv_q;
    hd_d     = hd_q;
    hk_d     = hk_q;
    ov_d     = ov_q;
    od_d     = od_q;
    ok_d     = ok_q;
    ol_d     = ol_q;
    err_d    = 1'b0;
    beat     = res_q | (in_if.data >> (8 * int'(r)));
    nres     = in_if.data << (8 * int'(n_q));
    hdr_full = in_if.data >> (8 * int'(r));

    if (hv_q && hdr_if.ready) hv_d = 1'b0;
    if (ov_q && out_if.ready) ov_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_extract_i) begin
          n_d     = popcnt(keep_extract_i);
          kc_d    = keep_extract_i;
          state_d = HDR;
        end
      end
      HDR: begin
        if (fire) begin
          hv_d  = 1'b1;
          hd_d  = hdr_full;
          hk_d  = kc_q;
          res_d = nres;
          if (!in_if.last) begin
            state_d = BODY;
          end else begin
            state_d = IDLE;
            if (k > n_q) begin
              ov_d = 1'b1;
              ok_d = top_ones(k - n_q);
              od_d = nres & bmask(top_ones(k - n_q));
              ol_d = 1'b1;
            end else if (k < n_q) begin
              hd_d  = (in_if.data & bmask(top_ones(k)))
                      >> (8 * (B - int'(k)));
              hk_d  = low_ones(k);
              err_d = 1'b1;
            end
          end
        end
      end
      BODY: begin
        if (fire) begin
          ov_d  = 1'b1;
          res_d = nres;
          od_d  = beat;
          ok_d  = '1;
          ol_d  = 1'b0;
          if (in_if.last && k <= n_q) begin
            ok_d    = top_ones(r + k);
            od_d    = beat & bmask(top_ones(r + k));
            ol_d    = 1'b1;
            state_d = IDLE;
          end else if (in_if.last) begin
            fk_d    = top_ones(k - n_q);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          ov_d    = 1'b1;
          od_d    = res_q & bmask(fk_q);
          ok_d    = fk_q;
          ol_d    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      kc_q    <= '0;
      res_q   <= '0;
      fk_q    <= '0;
      hv_q    <= 1'b0;
      hd_q    <= '0;
      hk_q    <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ok_q    <= '0;
      ol_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      kc_q    <= kc_d;
      res_q   <= res_d;
      fk_q    <= fk_d;
      hv_q    <= hv_d;
      hd_q    <= hd_d;
      hk_q    <= hk_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ok_q    <= ok_d;
      ol_q    <= ol_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed-vector bench for axi_stream_extract_header.
// Table of packets plus stall and mid-packet reset sequences.
module tb_axi_stream_extract_header;

  logic       clk;
  logic       rst;
  logic       valid_extract;
  logic [3:0] keep_extract;
  logic       ready_extract;
  logic       err_short;

  axi_stream_extract_header_if #(.DATA_WD(32)) in_if ();
  axi_stream_extract_header_if #(.DATA_WD(32)) hdr_if ();
  axi_stream_extract_header_if #(.DATA_WD(32)) out_if ();

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_extract_i (valid_extract),
    .keep_extract_i  (keep_extract),
    .ready_extract_o (ready_extract),
    .in_if           (in_if),
    .hdr_if          (hdr_if),
    .out_if          (out_if),
    .err_short_o     (err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  cfg;
    int          nb;
    logic [31:0] bd [6];
    logic [3:0]  bk [6];
    logic [31:0] hd;
    logic [3:0]  hk;
    int          np;
    logic [31:0] pd [6];
    logic [3:0]  pk [6];
    int          nerr;
  } vec_t;

  vec_t vecs [4];

  logic [31:0] got_pd [$];
  logic [3:0]  got_pk [$];
  logic        got_pl [$];
  logic [31:0] got_hd [$];
  logic [3:0]  got_hk [$];
  int          err_cnt;

  logic        tog_out;
  int          hhold;

  // output monitor, sampled mid-cycle
  logic        pv, ph;
  logic [31:0] pd_s, phd_s;
  logic [3:0]  pk_s, phk_s;
  logic        pl_s;

  initial begin
    pv = 0; ph = 0; err_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; ph = 0;
      end else begin
        if (pv) begin
          chk("out_hold_valid", 32'(out_if.valid), 32'd1);
          chk("out_hold_data", out_if.data, pd_s);
          chk("out_hold_keep", 32'(out_if.keep), 32'(pk_s));
          chk("out_hold_last", 32'(out_if.last), 32'(pl_s));
        end
        if (ph) begin
          chk("hdr_hold_valid", 32'(hdr_if.valid), 32'd1);
          chk("hdr_hold_data", hdr_if.data, phd_s);
        end
        pv = out_if.valid && !out_if.ready;
        pd_s = out_if.data; pk_s = out_if.keep; pl_s = out_if.last;
        ph = hdr_if.valid && !hdr_if.ready;
        phd_s = hdr_if.data; phk_s = hdr_if.keep;
        if (out_if.valid && out_if.ready) begin
          got_pd.push_back(out_if.data);
          got_pk.push_back(out_if.keep);
          got_pl.push_back(out_if.last);
        end
        if (hdr_if.valid && hdr_if.ready) begin
          got_hd.push_back(hdr_if.data);
          got_hk.push_back(hdr_if.keep);
        end
        if (err_short) err_cnt++;
      end
    end
  end

  initial begin
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_if.ready = tog_out ? ~out_if.ready : 1'b1;
    end
  end

  initial begin
    hdr_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hhold > 0) begin
        hdr_if.ready = 1'b0;
        hhold--;
      end else begin
        hdr_if.ready = 1'b1;
      end
    end
  end

  task automatic send_cfg(logic [3:0] k);
    int g;
    g = 0;
    valid_extract = 1'b1;
    keep_extract  = k;
    do begin
      @(negedge clk);
      g++;
    end while (!ready_extract && g < 200);
    if (!ready_extract) chk("cfg_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    valid_extract = 1'b0;
  endtask

  task automatic send_beat(logic [31:0] d, logic [3:0] k, logic l);
    int g;
    g = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.keep  = k;
    in_if.last  = l;
    do begin
      @(negedge clk);
      g++;
    end while (!in_if.ready && g < 200);
    if (!in_if.ready) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  task automatic clear_caps();
    got_pd.delete(); got_pk.delete(); got_pl.delete();
    got_hd.delete(); got_hk.delete();
    err_cnt = 0;
  endtask

  task automatic run_vec(vec_t v, string tag);
    clear_caps();
    send_cfg(v.cfg);
    for (int i = 0; i < v.nb; i++)
      send_beat(v.bd[i], v.bk[i], i == v.nb - 1);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_nhdr"}, 32'(got_hd.size()), 32'd1);
    if (got_hd.size() > 0) begin
      chk({tag, "_hdr"}, got_hd[0], v.hd);
      chk({tag, "_hkeep"}, 32'(got_hk[0]), 32'(v.hk));
    end
    chk({tag, "_npay"}, 32'(got_pd.size()), 32'(v.np));
    for (int i = 0; i < v.np && i < got_pd.size(); i++) begin
      chk($sformatf("%s_pd%0d", tag, i), got_pd[i], v.pd[i]);
      chk($sformatf("%s_pk%0d", tag, i), 32'(got_pk[i]), 32'(v.pk[i]));
      chk($sformatf("%s_pl%0d", tag, i), 32'(got_pl[i]),
          32'(i == v.np - 1));
    end
    chk({tag, "_err"}, 32'(err_cnt), 32'(v.nerr));
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_rdy_ext"}, 32'(ready_extract), 32'd1);
    chk({tag, "_rdy_in"}, 32'(in_if.ready), 32'd0);
    chk({tag, "_vhdr"}, 32'(hdr_if.valid), 32'd0);
    chk({tag, "_hdr"}, hdr_if.data, 32'd0);
    chk({tag, "_hkeep"}, 32'(hdr_if.keep), 32'd0);
    chk({tag, "_vout"}, 32'(out_if.valid), 32'd0);
    chk({tag, "_dout"}, out_if.data, 32'd0);
    chk({tag, "_kout"}, 32'(out_if.keep), 32'd0);
    chk({tag, "_lout"}, 32'(out_if.last), 32'd0);
    chk({tag, "_err"}, 32'(err_short), 32'd0);
  endtask

  initial begin
    vecs[0].cfg = 4'b0111; vecs[0].nb = 5;
    vecs[0].bd  = '{32'hAABBCCDD, 32'hEEFF0011, 32'h22334455,
                    32'h66778899, 32'h00AABBCC, 32'h0};
    vecs[0].bk  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'b1100, 4'h0};
    vecs[0].hd  = 32'h00AABBCC; vecs[0].hk = 4'b0111;
    vecs[0].np  = 4;
    vecs[0].pd  = '{32'hDDEEFF00, 32'h11223344, 32'h55667788,
                    32'h9900AA00, 32'h0, 32'h0};
    vecs[0].pk  = '{4'hF, 4'hF, 4'hF, 4'b1110, 4'h0, 4'h0};
    vecs[0].nerr = 0;

    vecs[1].cfg = 4'b0001; vecs[1].nb = 2;
    vecs[1].bd  = '{32'h11223344, 32'h55667788, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1].bk  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1].hd  = 32'h00000011; vecs[1].hk = 4'b0001;
    vecs[1].np  = 2;
    vecs[1].pd  = '{32'h22334455, 32'h66778800, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1].pk  = '{4'hF, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1].nerr = 0;

    vecs[2].cfg = 4'b1111; vecs[2].nb = 1;
    vecs[2].bd  = '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2].bk  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2].hd  = 32'hAABBCCDD; vecs[2].hk = 4'b1111;
    vecs[2].np  = 0;
    vecs[2].pd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2].pk  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2].nerr = 0;

    vecs[3].cfg = 4'b0111; vecs[3].nb = 1;
    vecs[3].bd  = '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3].bk  = '{4'b1000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[3].hd  = 32'h000000AA; vecs[3].hk = 4'b0001;
    vecs[3].np  = 0;
    vecs[3].pd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3].pk  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[3].nerr = 1;

    rst = 1'b1;
    valid_extract = 1'b0; keep_extract = 4'h0;
    in_if.valid = 1'b0; in_if.data = '0; in_if.keep = '0; in_if.last = 1'b0;
    tog_out = 1'b0; hhold = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_vec(vecs[i], $sformatf("v%0d", i + 1));

    // stalled payload and header consumers
    tog_out = 1'b1;
    hhold   = 5;
    run_vec(vecs[0], "stall");
    tog_out = 1'b0;
    repeat (3) @(posedge clk); #1;

    // reset in the middle of a packet, then a clean packet
    clear_caps();
    send_cfg(vecs[0].cfg);
    send_beat(vecs[0].bd[0], vecs[0].bk[0], 1'b0);
    send_beat(vecs[0].bd[1], vecs[0].bk[1], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(vecs[1], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
